player_attack_ctrl: RTL and testbench

PLAYER_ATTACK_CTRL -- requirements
Module: player_attack_ctrl

---
 rtl/player_anim_pkg.sv | 30 +++
 rtl/btn_edge.sv | 25 ++
 rtl/player_attack_ctrl.sv | 173 +++++++++++++++++
 tb/tb_player_attack_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/player_anim_pkg.sv
// Shared attack definitions for the player attack controller and the
// animation state block: attack type codes, controller FSM states and the
// default phase lengths (in game-frame ticks).
package player_anim_pkg;

  typedef enum logic [1:0] {
    ATK_NONE  = 2'd0,
    ATK_LIGHT = 2'd1,
    ATK_HEAVY = 2'd2
  } attack_type_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STARTUP  = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_RECOVERY = 3'd3,
    ST_COOLDOWN = 3'd4
  } atk_state_e;

  localparam int unsigned DEF_STARTUP1  = 3;
  localparam int unsigned DEF_ACTIVE1   = 2;
  localparam int unsigned DEF_RECOVERY1 = 5;
  localparam int unsigned DEF_STARTUP2  = 6;
  localparam int unsigned DEF_ACTIVE2   = 4;
  localparam int unsigned DEF_RECOVERY2 = 10;
  localparam int unsigned DEF_COOLDOWN  = 4;

  localparam int unsigned FRAME_W = 6;

endpackage

// File: rtl/btn_edge.sv
// Tick-gated rising-edge detector for one synchronised button.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   scen_i      - game-frame tick enable; history only advances on ticks
//   btn_i       - button level
//   rise_o      - high on a tick where btn_i=1 and it was 0 on the last tick
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic scen_i,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  // History resets to 1 so a button held through reset does not fire.
  always_ff @(posedge clk) begin
    if (reset)       prev_q <= 1'b1;
    else if (scen_i) prev_q <= btn_i;
  end

  assign rise_o = scen_i & btn_i & ~prev_q;

endmodule

// File: rtl/player_attack_ctrl.sv
// Player attack controller: launches light/heavy attacks on button presses,
// steps them through startup/active/recovery, then a cooldown lockout.
// One-deep press buffer during recovery/cooldown; hitstun aborts everything.
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   SCEN              - game-frame tick enable
//   btn_atk1/btn_atk2 - light / heavy buttons (synchronised levels)
//   hitstun_active    - player is being hit
//   attack_active     - startup, active or recovery phase
//   attack_type       - 0 none, 1 light, 2 heavy
//   attack_frame      - tick index within the attack
//   hitbox_active     - active phase only
//   cooldown_active   - post-attack lockout
//
// state    | meaning
// IDLE     | no attack, ready to launch
// STARTUP  | wind-up frames, no hitbox
// ACTIVE   | hitbox live
// RECOVERY | wind-down, presses buffered
// COOLDOWN | lockout, presses buffered
module player_attack_ctrl
  import player_anim_pkg::*;
#(
  parameter int unsigned STARTUP1  = DEF_STARTUP1,
  parameter int unsigned ACTIVE1   = DEF_ACTIVE1,
  parameter int unsigned RECOVERY1 = DEF_RECOVERY1,
  parameter int unsigned STARTUP2  = DEF_STARTUP2,
  parameter int unsigned ACTIVE2   = DEF_ACTIVE2,
  parameter int unsigned RECOVERY2 = DEF_RECOVERY2,
  parameter int unsigned COOLDOWN  = DEF_COOLDOWN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               SCEN,
  input  logic               btn_atk1,
  input  logic               btn_atk2,
  input  logic               hitstun_active,
  output logic               attack_active,
  output logic [1:0]         attack_type,
  output logic [FRAME_W-1:0] attack_frame,
  output logic               hitbox_active,
  output logic               cooldown_active
);

  localparam logic [FRAME_W-1:0] S1   = FRAME_W'(STARTUP1);
  localparam logic [FRAME_W-1:0] SA1  = FRAME_W'(STARTUP1 + ACTIVE1);
  localparam logic [FRAME_W-1:0] END1 = FRAME_W'(STARTUP1 + ACTIVE1 + RECOVERY1 - 1);
  localparam logic [FRAME_W-1:0] S2   = FRAME_W'(STARTUP2);
  localparam logic [FRAME_W-1:0] SA2  = FRAME_W'(STARTUP2 + ACTIVE2);
  localparam logic [FRAME_W-1:0] END2 = FRAME_W'(STARTUP2 + ACTIVE2 + RECOVERY2 - 1);
  localparam logic [FRAME_W-1:0] CD   = FRAME_W'(COOLDOWN);

  atk_state_e         state_q, state_d;
  attack_type_e       type_q, type_d;
  attack_type_e       buf_q, buf_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] cd_q, cd_d;

  logic               rise1, rise2;
  attack_type_e       press;
  attack_type_e       launch;
  logic [FRAME_W-1:0] ph_s, ph_sa, ph_end;
  logic [FRAME_W-1:0] frame_nx;

  btn_edge u_edge_atk1 (.clk(clk), .reset(reset), .scen_i(SCEN), .btn_i(btn_atk1), .rise_o(rise1));
  btn_edge u_edge_atk2 (.clk(clk), .reset(reset), .scen_i(SCEN), .btn_i(btn_atk2), .rise_o(rise2));

  // Light wins a simultaneous press; the heavy edge is simply dropped.
  assign press    = rise1 ? ATK_LIGHT : (rise2 ? ATK_HEAVY : ATK_NONE);
  // A fresh press overrides whatever was buffered earlier.
  assign launch   = (press != ATK_NONE) ? press : buf_q;
  assign frame_nx = frame_q + 1'b1;

  always_comb begin
    ph_s   = S1;
    ph_sa  = SA1;
    ph_end = END1;
    if (type_q == ATK_HEAVY) begin
      ph_s   = S2;
      ph_sa  = SA2;
      ph_end = END2;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    buf_d   = buf_q;
    frame_d = frame_q;
    cd_d    = cd_q;
    if (SCEN) begin
      if (hitstun_active) begin
        state_d = ST_IDLE;
        type_d  = ATK_NONE;
        buf_d   = ATK_NONE;
        frame_d = '0;
        cd_d    = '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (launch != ATK_NONE) begin
              state_d = ST_STARTUP;
              type_d  = launch;
              frame_d = '0;
              buf_d   = ATK_NONE;
            end
          end
          ST_STARTUP: begin
            frame_d = frame_nx;
            if (frame_nx == ph_s) state_d = ST_ACTIVE;
          end
          ST_ACTIVE: begin
            frame_d = frame_nx;
            if (frame_nx == ph_sa) state_d = ST_RECOVERY;
          end
          ST_RECOVERY: begin
            if (press != ATK_NONE) buf_d = press;
            if (frame_q == ph_end) begin
              state_d = ST_COOLDOWN;
              type_d  = ATK_NONE;
              frame_d = '0;
              cd_d    = CD;
            end else begin
              frame_d = frame_nx;
            end
          end
          ST_COOLDOWN: begin
            if (cd_q == FRAME_W'(1)) begin
              cd_d  = '0;
              buf_d = ATK_NONE;
              if (launch != ATK_NONE) begin
                state_d = ST_STARTUP;
                type_d  = launch;
                frame_d = '0;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              cd_d = cd_q - 1'b1;
              if (press != ATK_NONE) buf_d = press;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      type_q  <= ATK_NONE;
      buf_q   <= ATK_NONE;
      frame_q <= '0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      buf_q   <= buf_d;
      frame_q <= frame_d;
      cd_q    <= cd_d;
    end
  end

  // Pure decodes of registered state: no input reaches an output combinationally.
  assign attack_active   = (state_q == ST_STARTUP) || (state_q == ST_ACTIVE) ||
                           (state_q == ST_RECOVERY);
  assign attack_type     = type_q;
  assign attack_frame    = frame_q;
  assign hitbox_active   = (state_q == ST_ACTIVE);
  assign cooldown_active = (state_q == ST_COOLDOWN);

endmodule

// File: tb/tb_player_attack_ctrl.sv
module tb_player_attack_ctrl;

  localparam int T_S[3] = '{0, 3, 6};
  localparam int T_A[3] = '{0, 2, 4};
  localparam int T_R[3] = '{0, 5, 10};
  localparam int T_CD   = 4;

  logic       clk = 1'b0;
  logic       reset, SCEN, btn_atk1, btn_atk2, hitstun_active;
  logic       attack_active, hitbox_active, cooldown_active;
  logic [1:0] attack_type;
  logic [5:0] attack_frame;

  player_attack_ctrl dut (
    .clk(clk), .reset(reset), .SCEN(SCEN), .btn_atk1(btn_atk1), .btn_atk2(btn_atk2),
    .hitstun_active(hitstun_active), .attack_active(attack_active), .attack_type(attack_type),
    .attack_frame(attack_frame), .hitbox_active(hitbox_active), .cooldown_active(cooldown_active)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: attack kind, ticks since launch, remaining lockout ticks, pending press
  int m_type = 0;
  int m_t = 0;
  int m_cd = 0;
  int m_pend = 0;
  bit m_p1 = 1'b1, m_p2 = 1'b1;

  bit b1_l = 1'b0, b2_l = 1'b0;
  int c_act, c_hit, c_cd, c_heavy, c_idle;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit b1, input bit b2, input bit hs);
    int pr;
    if (r) begin
      m_type = 0; m_t = 0; m_cd = 0; m_pend = 0; m_p1 = 1'b1; m_p2 = 1'b1;
    end else if (s) begin
      pr = (b1 && !m_p1) ? 1 : ((b2 && !m_p2) ? 2 : 0);
      m_p1 = b1; m_p2 = b2;
      if (hs) begin
        m_type = 0; m_t = 0; m_cd = 0; m_pend = 0;
      end else if (m_type != 0) begin
        if (m_t >= T_S[m_type] + T_A[m_type] && pr != 0) m_pend = pr;
        if (m_t == T_S[m_type] + T_A[m_type] + T_R[m_type] - 1) begin
          m_type = 0; m_t = 0; m_cd = T_CD;
        end else begin
          m_t++;
        end
      end else if (m_cd > 0) begin
        if (pr != 0) m_pend = pr;
        m_cd--;
        if (m_cd == 0) begin
          if (m_pend != 0) begin m_type = m_pend; m_t = 0; end
          m_pend = 0;
        end
      end else if (pr != 0) begin
        m_type = pr; m_t = 0;
      end
    end
  endtask

  task automatic tk(input bit r, input bit s, input bit hs);
    reset = r; SCEN = s; btn_atk1 = b1_l; btn_atk2 = b2_l; hitstun_active = hs;
    @(posedge clk);
    model_step(r, s, b1_l, b2_l, hs);
    @(negedge clk);
    chk("attack_active", int'(attack_active), int'(m_type != 0));
    chk("attack_type", int'(attack_type), m_type);
    chk("attack_frame", int'(attack_frame), m_t);
    chk("hitbox_active", int'(hitbox_active),
        int'(m_type != 0 && m_t >= T_S[m_type] && m_t < T_S[m_type] + T_A[m_type]));
    chk("cooldown_active", int'(cooldown_active), int'(m_cd > 0));
    if (attack_active) c_act++;
    if (hitbox_active) c_hit++;
    if (cooldown_active) c_cd++;
    if (attack_type == 2'd2) c_heavy++;
    if (!attack_active && !cooldown_active) c_idle++;
  endtask

  task automatic clr();
    c_act = 0; c_hit = 0; c_cd = 0; c_heavy = 0; c_idle = 0;
  endtask

  task automatic idle_run(input int n);
    b1_l = 1'b0; b2_l = 1'b0;
    for (int i = 0; i < n; i++) tk(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    clr();
    tk(1'b1, 1'b1, 1'b0);
    tk(1'b1, 1'b0, 1'b0);
    chk("reset_active", int'(attack_active), 0);
    chk("reset_cooldown", int'(cooldown_active), 0);
    idle_run(3);

    // light attack
    clr();
    b1_l = 1'b1; tk(1'b0, 1'b1, 1'b0);
    chk("light_launch_frame", int'(attack_frame), 0);
    idle_run(20);
    chk("light_len", c_act, 10);
    chk("light_hitbox", c_hit, 2);
    chk("light_cooldown", c_cd, 4);

    // heavy attack
    clr();
    b2_l = 1'b1; tk(1'b0, 1'b1, 1'b0);
    idle_run(30);
    chk("heavy_len", c_act, 20);
    chk("heavy_hitbox", c_hit, 4);
    chk("heavy_type_ticks", c_heavy, 20);

    // simultaneous press: light wins, heavy dropped
    clr();
    b1_l = 1'b1; b2_l = 1'b1; tk(1'b0, 1'b1, 1'b0);
    idle_run(40);
    chk("both_light_len", c_act, 10);
    chk("both_no_heavy", c_heavy, 0);

    // heavy buffered during light recovery launches straight out of cooldown
    clr();
    b1_l = 1'b1; tk(1'b0, 1'b1, 1'b0);
    b1_l = 1'b0;
    for (int i = 0; i < 7; i++) tk(1'b0, 1'b1, 1'b0);
    b2_l = 1'b1; tk(1'b0, 1'b1, 1'b0);
    b2_l = 1'b0;
    for (int i = 0; i < 25; i++) tk(1'b0, 1'b1, 1'b0);
    chk("buffer_no_idle", c_idle, 0);
    chk("buffer_heavy_ticks", c_heavy, 20);
    idle_run(10);

    // hitstun at heavy frame 7, press during hitstun discarded
    b2_l = 1'b1; tk(1'b0, 1'b1, 1'b0);
    b2_l = 1'b0;
    for (int i = 0; i < 7; i++) tk(1'b0, 1'b1, 1'b0);
    tk(1'b0, 1'b1, 1'b1);
    chk("hitstun_active_out", int'(attack_active), 0);
    chk("hitstun_frame", int'(attack_frame), 0);
    clr();
    b1_l = 1'b1; tk(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tk(1'b0, 1'b1, 1'b0);
    chk("hitstun_press_dropped", c_act, 0);
    idle_run(5);

    // held through reset, SCEN every 4th clock
    b1_l = 1'b1;
    tk(1'b1, 1'b1, 1'b0);
    tk(1'b1, 1'b0, 1'b0);
    clr();
    for (int i = 0; i < 16; i++) tk(1'b0, (i % 4) == 0, 1'b0);
    chk("held_reset_no_fire", c_act, 0);
    b1_l = 1'b0;
    for (int i = 0; i < 8; i++) tk(1'b0, (i % 4) == 0, 1'b0);
    clr();
    b1_l = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 4) b1_l = 1'b0;
      tk(1'b0, (i % 4) == 0, 1'b0);
    end
    chk("slow_scen_len", c_act, 40);
    chk("slow_scen_cd", c_cd, 16);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) b1_l = ~b1_l;
      if ($urandom_range(0, 7) == 0) b2_l = ~b2_l;
      tk($urandom_range(0, 999) < 3, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
